// File: rtl/cherry_spawn_ctrl_if.sv
// Occupancy-check handshake between the cherry spawner and the snake-body checker.
// master: spawner (issues candidate + req), slave: checker (returns ack + hit).
interface cherry_spawn_ctrl_if;
  logic       chk_req;
  logic [9:0] chk_x;
  logic [8:0] chk_y;
  logic       chk_ack;
  logic       chk_hit;

  modport master (
    output chk_req,
    output chk_x,
    output chk_y,
    input  chk_ack,
    input  chk_hit
  );

  modport slave (
    input  chk_req,
    input  chk_x,
    input  chk_y,
    output chk_ack,
    output chk_hit
  );
endinterface

// File: rtl/cherry_spawn_ctrl.sv
// Cherry spawn controller: after the snake eats the cherry, steps a candidate position
// (LFSR-seeded reload on wrap), asks the occupancy checker whether it overlaps the snake,
// retries on overlap up to MAX_RETRY checks, then commits the position for rendering.
// Optional macro CHERRY_SCORE_EN adds a saturating 8-bit eat counter on port score.
module cherry_spawn_ctrl #(
  parameter int unsigned X_MIN     = 20,
  parameter int unsigned X_MAX     = 570,
  parameter int unsigned Y_MIN     = 20,
  parameter int unsigned Y_MAX     = 400,
  parameter int unsigned X_STEP    = 48,
  parameter int unsigned Y_STEP    = 31,
  parameter int unsigned INIT_X    = 100,
  parameter int unsigned INIT_Y    = 80,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                eat_req,
  input  logic [5:0]          rand_q,
  cherry_spawn_ctrl_if.master chk,
  output logic [9:0]          cherry_x,
  output logic [8:0]          cherry_y,
  output logic                cherry_valid,
  output logic                spawn_done,
  output logic                retry_exhausted
`ifdef CHERRY_SCORE_EN
  ,
  output logic [7:0]          score
`endif
);

  typedef enum logic [1:0] {StIdle, StGen, StCheck, StPlace} state_e;

  localparam logic [3:0] LastRetry = 4'(MAX_RETRY - 1);

  state_e     state;
  logic [9:0] cand_x;
  logic [8:0] cand_y;
  logic [3:0] retry_cnt;

  logic [10:0] sx;
  logic [9:0]  sy;
  logic [9:0]  next_x;
  logic [8:0]  next_y;

  // Next candidate: step by a fixed stride, reload from the LFSR sample when out of bounds.
  always_comb begin
    sx     = {1'b0, cand_x} + 11'(X_STEP);
    sy     = {1'b0, cand_y} + 10'(Y_STEP);
    next_x = sx[9:0];
    next_y = sy[8:0];
    if (sx >= 11'(X_MAX) || sx <= 11'(X_MIN)) begin
      next_x = 10'(rand_q) + 10'(X_MIN);
    end
    if (sy >= 10'(Y_MAX) || sy <= 10'(Y_MIN)) begin
      next_y = 9'(rand_q) + 9'(Y_MIN);
    end
  end

  // Spawn sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= StIdle;
      cherry_x        <= 10'(INIT_X);
      cherry_y        <= 9'(INIT_Y);
      cherry_valid    <= 1'b1;
      cand_x          <= 10'(INIT_X);
      cand_y          <= 9'(INIT_Y);
      chk.chk_req     <= 1'b0;
      chk.chk_x       <= '0;
      chk.chk_y       <= '0;
      spawn_done      <= 1'b0;
      retry_exhausted <= 1'b0;
      retry_cnt       <= '0;
`ifdef CHERRY_SCORE_EN
      score           <= '0;
`endif
    end else begin
      spawn_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (eat_req) begin
            cherry_valid <= 1'b0;
            retry_cnt    <= '0;
            state        <= StGen;
`ifdef CHERRY_SCORE_EN
            if (score != 8'hff) score <= score + 8'd1;
`endif
          end
        end
        StGen: begin
          cand_x      <= next_x;
          cand_y      <= next_y;
          chk.chk_x   <= next_x;
          chk.chk_y   <= next_y;
          chk.chk_req <= 1'b1;
          state       <= StCheck;
        end
        StCheck: begin
          // No timeout: the checker is trusted to answer eventually.
          if (chk.chk_ack) begin
            chk.chk_req <= 1'b0;
            if (!chk.chk_hit) begin
              state <= StPlace;
            end else if (retry_cnt == LastRetry) begin
              // Out of retries: place on the overlapping candidate and flag it.
              retry_exhausted <= 1'b1;
              state           <= StPlace;
            end else begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= StGen;
            end
          end
        end
        StPlace: begin
          cherry_x     <= cand_x;
          cherry_y     <= cand_y;
          cherry_valid <= 1'b1;
          spawn_done   <= 1'b1;
          state        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cherry_spawn_ctrl.sv
// Scoreboard bench for cherry_spawn_ctrl: stimulus pushes expected checks and placements,
// a checker responder plays the occupancy checker, and a monitor pops and compares.
module tb_cherry_spawn_ctrl;

  localparam int XMin = 20, XMax = 570, YMin = 20, YMax = 400;
  localparam int XStep = 48, YStep = 31, InitX = 100, InitY = 80, MaxRetry = 15;

  typedef struct {
    int x;
    int y;
  } chk_exp_t;

  typedef struct {
    int x;
    int y;
    int lat;
    int score;
    bit exh;
  } place_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       eat_req;
  logic [5:0] rand_q;
  logic [9:0] cherry_x;
  logic [8:0] cherry_y;
  logic       cherry_valid;
  logic       spawn_done;
  logic       retry_exhausted;
`ifdef CHERRY_SCORE_EN
  logic [7:0] score;
`endif

  cherry_spawn_ctrl_if chk_if ();

  cherry_spawn_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .eat_req         (eat_req),
    .rand_q          (rand_q),
    .chk             (chk_if.master),
    .cherry_x        (cherry_x),
    .cherry_y        (cherry_y),
    .cherry_valid    (cherry_valid),
    .spawn_done      (spawn_done),
    .retry_exhausted (retry_exhausted)
`ifdef CHERRY_SCORE_EN
    ,
    .score           (score)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  chk_exp_t   chk_q[$];
  place_exp_t place_q[$];
  bit         hit_q[$];
  int         delay_q[$];
  bit         resp_hold = 1'b0;

  // Reference model state: where the next spawn steps from.
  int mx = InitX, my = InitY, mscore = 0;
  bit mexh = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mx = InitX;
    my = InitY;
    mexh = 1'b0;
    mscore = 0;
  endfunction

  // One candidate step: fixed stride, reload to seed + lower bound when leaving the field.
  function automatic void model_step(input int r);
    int sx, sy;
    sx = mx + XStep;
    sy = my + YStep;
    mx = (sx >= XMax || sx <= XMin) ? r + XMin : sx;
    my = (sy >= YMax || sy <= YMin) ? r + YMin : sy;
  endfunction

  // Plans one spawn: nhit overlapping answers before a miss (>= MaxRetry means all hit).
  task automatic spawn(input int nhit, input int maxd, input bit drop_eat);
    int r, last, lat, d;
    place_exp_t p;
    chk_exp_t c;
    r = $urandom_range(0, 63);
    rand_q = 6'(r);
    last = (nhit < MaxRetry) ? nhit : MaxRetry - 1;
    lat = 1;
    for (int k = 0; k <= last; k++) begin
      model_step(r);
      c.x = mx;
      c.y = my;
      chk_q.push_back(c);
      d = (maxd > 0) ? $urandom_range(0, maxd) : 0;
      delay_q.push_back(d);
      hit_q.push_back(k < nhit);
      lat += 2 + d;
    end
    if (nhit >= MaxRetry) mexh = 1'b1;
    if (mscore < 255) mscore++;
    p.x = mx;
    p.y = my;
    p.lat = lat;
    p.score = mscore;
    p.exh = mexh;
    place_q.push_back(p);
    eat_req = 1'b1;
    @(negedge clk);
    eat_req = 1'b0;
    if (drop_eat) begin
      for (int t = 0; t < 20 && !chk_if.chk_req; t++) @(negedge clk);
      if (chk_if.chk_req) begin
        eat_req = 1'b1;
        @(negedge clk);
        eat_req = 1'b0;
      end
    end
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 500 && !seen; t++) begin
        @(posedge clk);
        #1;
        seen = spawn_done;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL spawn_timeout: got no spawn_done required one within 500 cycles");
      end
    end
    @(negedge clk);
  endtask

  // Occupancy-checker stand-in: answers each request after a planned delay, and throws
  // stray acks while no request is pending.
  initial begin
    int dly = 0;
    bit waiting = 1'b0;
    chk_if.chk_ack = 1'b0;
    chk_if.chk_hit = 1'b0;
    forever begin
      @(negedge clk);
      chk_if.chk_ack = 1'b0;
      chk_if.chk_hit = 1'($urandom);
      if (!reset) begin
        waiting = 1'b0;
      end else if (chk_if.chk_req && !resp_hold) begin
        if (!waiting) begin
          waiting = 1'b1;
          dly = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end
        if (dly == 0) begin
          chk_if.chk_ack = 1'b1;
          chk_if.chk_hit = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
          waiting = 1'b0;
        end else begin
          dly--;
        end
      end else if (!chk_if.chk_req && $urandom_range(0, 3) == 0) begin
        chk_if.chk_ack = 1'b1;
      end
    end
  end

  // Monitor: compares each new check request and each committed placement.
  initial begin
    bit prev_req = 1'b0, active = 1'b0;
    int cyc = 0, eat_cyc = 0, hx = 0, hy = 0, last_x = InitX, last_y = InitY;
    chk_exp_t c;
    place_exp_t p;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        prev_req = 1'b0;
        active = 1'b0;
        last_x = int'(cherry_x);
        last_y = int'(cherry_y);
        continue;
      end
      if (eat_req && !active) begin
        active = 1'b1;
        eat_cyc = cyc;
      end
      if (chk_if.chk_req && !prev_req) begin
        if (chk_q.size() == 0) begin
          check("unexpected_check", 1, 0);
        end else begin
          c = chk_q.pop_front();
          check("chk_x", int'(chk_if.chk_x), c.x);
          check("chk_y", int'(chk_if.chk_y), c.y);
        end
        hx = int'(chk_if.chk_x);
        hy = int'(chk_if.chk_y);
      end else if (chk_if.chk_req) begin
        check("chk_x_stable", int'(chk_if.chk_x), hx);
        check("chk_y_stable", int'(chk_if.chk_y), hy);
      end
      if (spawn_done) begin
        if (place_q.size() == 0) begin
          check("unexpected_place", 1, 0);
        end else begin
          p = place_q.pop_front();
          check("cherry_x", int'(cherry_x), p.x);
          check("cherry_y", int'(cherry_y), p.y);
          check("cherry_valid_placed", int'(cherry_valid), 1);
          check("retry_exhausted", int'(retry_exhausted), int'(p.exh));
          check("spawn_latency", cyc - eat_cyc, p.lat);
`ifdef CHERRY_SCORE_EN
          check("score", int'(score), p.score);
`endif
        end
        active = 1'b0;
      end else begin
        if (active) check("cherry_valid_low", int'(cherry_valid), 0);
        if (int'(cherry_x) != last_x || int'(cherry_y) != last_y) begin
          check("cherry_moved_outside_place", 1, 0);
        end
      end
      last_x = int'(cherry_x);
      last_y = int'(cherry_y);
      prev_req = chk_if.chk_req;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cherry_x"}, int'(cherry_x), InitX);
    check({tag, "_cherry_y"}, int'(cherry_y), InitY);
    check({tag, "_cherry_valid"}, int'(cherry_valid), 1);
    check({tag, "_chk_req"}, int'(chk_if.chk_req), 0);
    check({tag, "_retry_exhausted"}, int'(retry_exhausted), 0);
    check({tag, "_spawn_done"}, int'(spawn_done), 0);
`ifdef CHERRY_SCORE_EN
    check({tag, "_score"}, int'(score), 0);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_q.delete();
    place_q.delete();
    hit_q.delete();
    delay_q.delete();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    eat_req = 1'b0;
    rand_q = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_chk_x", int'(chk_if.chk_x), 0);
    check("reset_chk_y", int'(chk_if.chk_y), 0);
    @(negedge clk);

    // First spawn, immediate miss: (148,111) after three cycles.
    spawn(0, 0, 1'b0);

    // Two hits then a miss from the reset candidate.
    apply_reset();
    @(negedge clk);
    spawn(2, 0, 1'b0);

    // All hits: exactly MaxRetry checks, then a normal spawn keeps the sticky flag.
    spawn(MaxRetry, 1, 1'b0);
    spawn(0, 2, 1'b0);

    // Randomised spawns with delays, retries, dropped eats and idle gaps.
    for (int i = 0; i < 40; i++) begin
      int nh;
      nh = ($urandom_range(0, 9) == 0) ? MaxRetry : $urandom_range(0, 5);
      spawn(nh, 3, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset while a check is stalled: request must drop without waiting for a clock.
    apply_reset();
    @(negedge clk);
    resp_hold = 1'b1;
    begin
      chk_exp_t c;
      model_step(int'(rand_q));
      c.x = mx;
      c.y = my;
      chk_q.push_back(c);
    end
    eat_req = 1'b1;
    @(negedge clk);
    eat_req = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_chk_req_high", int'(chk_if.chk_req), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_chk_req_drop", int'(chk_if.chk_req), 0);
    @(negedge clk);
    chk_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midcheck_reset");
    resp_hold = 1'b0;
    @(negedge clk);
    spawn(1, 2, 1'b0);

    repeat (5) @(negedge clk);
    check("chk_queue_drained", chk_q.size(), 0);
    check("place_queue_drained", place_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cherry_spawn_ctrl.md
Name: cherry_spawn_ctrl

Overview:
- Sequences placement of the next cherry after the snake eats the current one.
- Steps a candidate position using the 6-bit LFSR value from rand_num_generator as a reload seed.
- Asks the snake-body occupancy checker, over a req/ack handshake, whether the candidate overlaps the snake. Retries on overlap.
- Publishes the accepted position to the cherry pixel renderer.

Parameters:
- X_MIN, 20: lower x bound; also the reload offset for x.
- X_MAX, 570: x wrap threshold.
- Y_MIN, 20: lower y bound; also the reload offset for y.
- Y_MAX, 400: y wrap threshold.
- X_STEP, 48: x increment per candidate.
- Y_STEP, 31: y increment per candidate.
- INIT_X, 100: cherry x after reset.
- INIT_Y, 80: cherry y after reset.
- MAX_RETRY, 15: maximum occupancy checks per spawn (1..15).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- eat_req  in  1  one-cycle pulse: snake head hit the cherry.
- rand_q  in  6  LFSR value, sampled in GEN.
- chk_req  out  1  occupancy check request.
- chk_x  out  10  candidate x under check.
- chk_y  out  9  candidate y under check.
- chk_ack  in  1  checker response valid; one-cycle pulse.
- chk_hit  in  1  candidate overlaps the snake; valid only while chk_ack=1.
- cherry_x  out  10  placed cherry x (top-left corner).
- cherry_y  out  9  placed cherry y.
- cherry_valid  out  1  1 = a cherry is placed and drawable.
- spawn_done  out  1  one-cycle pulse when a new position is committed.
- retry_exhausted  out  1  sticky flag: a spawn hit MAX_RETRY.

Behaviour:
- States: IDLE, GEN, CHECK, PLACE. All outputs are registered.
- Reset (async assert, sync release):
  - state=IDLE, cherry_x=INIT_X, cherry_y=INIT_Y, cherry_valid=1.
  - cand_x=INIT_X, cand_y=INIT_Y, chk_req=0, spawn_done=0, retry_exhausted=0, retry_cnt=0.
  - chk_x/chk_y = 0.
- IDLE:
  - eat_req=1 → cherry_valid<=0, retry_cnt<=0, go to GEN.
  - eat_req in any other state is dropped, not queued.
- GEN (exactly 1 cycle):
  - sx = cand_x + X_STEP, computed 11-bit. If sx >= X_MAX or sx <= X_MIN, then cand_x <= rand_q + X_MIN; else cand_x <= sx[9:0].
  - sy = cand_y + Y_STEP, computed 10-bit. If sy >= Y_MAX or sy <= Y_MIN, then cand_y <= rand_q + Y_MIN; else cand_y <= sy[8:0].
  - x and y use the same rand_q sample.
  - Drive chk_x/chk_y with the new candidate, set chk_req<=1, go to CHECK.
- CHECK:
  - chk_req, chk_x and chk_y are held stable until chk_ack=1; there is no timeout.
  - On ack, chk_req<=0 in the same edge.
  - chk_hit=0 → PLACE.
  - chk_hit=1 and retry_cnt == MAX_RETRY-1 → PLACE anyway with the current candidate, and set retry_exhausted<=1.
  - chk_hit=1 otherwise → retry_cnt++, go to GEN.
  - chk_ack outside CHECK is ignored.
- PLACE (1 cycle): cherry_x<=cand_x, cherry_y<=cand_y, cherry_valid<=1, spawn_done<=1 for one cycle, go to IDLE.
- Latency with an immediate ack: eat_req sampled at edge E → cherry_valid low after E. Then GEN at E+1, CHECK at E+2, PLACE at E+3. cherry_valid=1 and spawn_done=1 after edge E+3. Each retry adds 2 cycles plus the ack wait.
- cherry_x/cherry_y never change outside PLACE.
- The candidate persists across spawns: the next spawn steps from the last candidate, not from cherry_x.
- retry_exhausted clears only on reset.
- Reset mid-CHECK: chk_req falls asynchronously. The cherry returns to INIT_X/INIT_Y with cherry_valid=1.

Optional Feature:
- Macro: CHERRY_SCORE_EN.
- Defined: adds output score[7:0].
  - Reset value 0.
  - Increments on every accepted eat_req in IDLE.
  - Saturates at 255.
- Undefined: no score port and no counter logic.

Test Plan:
- Reset release → cherry_x=100, cherry_y=80, cherry_valid=1, chk_req=0, retry_exhausted=0.
- eat_req pulse, checker acks chk_hit=0 on the first CHECK cycle:
  - chk_x=148, chk_y=111.
  - cherry_valid low for 3 cycles, then cherry_x=148, cherry_y=111 with a spawn_done pulse.
- Wrap: cand_x=532, cand_y=380, rand_q=5, eat_req with a no-hit ack:
  - sx=580 reloads cand_x=25; sy=411 reloads cand_y=25.
  - Placed at (25,25).
- Retry: acks hit, hit, miss starting from (100,80):
  - Three req/ack cycles at (148,111), (196,142), (244,173).
  - Placed at (244,173); retry_exhausted=0.
- Exhaustion: every ack returns hit → exactly 15 checks, placement at the 15th candidate, retry_exhausted=1. A second eat_req still spawns normally.
- Reset asserted while chk_req=1 and the checker is stalled → chk_req=0 immediately; after release, cherry at (100,80) and cherry_valid=1.
- Under CHERRY_SCORE_EN: 3 accepted eats → score=3. An eat_req during CHECK leaves score unchanged.
